// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: round-robin arbiter that serializes requester register
// writes into 16-bit mode-0 SPI write frames with slow, fully registered pins.
module spi_cfg_sequencer #(
   parameter int NUM_REQ = 2,
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   input  logic [7*NUM_REQ-1:0]   req_addr_i,
   input  logic [8*NUM_REQ-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [2:0]             done_id_o,
   output logic                   ncs_o,
   output logic                   sclk_o,
   output logic                   copi_o
);
   localparam int MAXC = CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP;
   localparam int CW = $clog2(MAXC) + 1;
   localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_END = CW'(CS_GAP - 1);

   typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, CS_HOLD, GAP} state_t;

   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0] bit_q, bit_d;
   logic [15:0] frame_q, frame_d;
   logic [2:0] ptr_q, ptr_d, id_q, id_d;
   logic ncs_q, ncs_d, sclk_q, sclk_d, copi_q, copi_d, done_q, done_d;
   logic [2:0] done_id_q, done_id_d;
   logic [7:0] vld8;
   logic grant_vld;
   logic [2:0] grant_id;
   logic [NUM_REQ-1:0] grant;
   logic [6:0] sel_addr;
   logic [7:0] sel_data;

   assign vld8 = 8'(req_valid_i);

   // Scan downward so the requester nearest the pointer is the last (winning) hit.
   always_comb begin
      grant_vld = 1'b0;
      grant_id = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (vld8[3'((int'(ptr_q) + k) % NUM_REQ)]) begin
            grant_vld = 1'b1;
            grant_id = 3'((int'(ptr_q) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      grant = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == 3'(i)) begin
            grant[i] = grant_vld;
            sel_addr = req_addr_i[7*i +: 7];
            sel_data = req_data_i[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q + 1'b1;
      bit_d = bit_q;
      frame_d = frame_q;
      ptr_d = ptr_q;
      id_d = id_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (grant_vld) begin
               frame_d = {1'b1, sel_addr, sel_data};
               ptr_d = 3'((int'(grant_id) + 1) % NUM_REQ);
               id_d = grant_id;
               bit_d = 4'd15;
               state_d = SHIFT_LO;
            end
         end
         SHIFT_LO: if (cnt_q == DIV_END) state_d = SHIFT_HI;
         SHIFT_HI: begin
            if (cnt_q == DIV_END) begin
               if (bit_q != 4'd0) begin
                  bit_d = bit_q - 1'b1;
                  state_d = SHIFT_LO;
               end else begin
                  state_d = CS_HOLD;
               end
            end
         end
         CS_HOLD: if (cnt_q == DIV_END) state_d = GAP;
         GAP: if (cnt_q == GAP_END) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
      // Pins are decoded from the next state so they line up with the state register.
      ncs_d = !(state_d == SHIFT_LO || state_d == SHIFT_HI || state_d == CS_HOLD);
      sclk_d = state_d == SHIFT_HI;
      copi_d = state_d == SHIFT_LO ? frame_d[bit_d] :
               (state_d == SHIFT_HI || state_d == CS_HOLD) ? copi_q : 1'b0;
      done_d = state_d == GAP && state_q != GAP;
      done_id_d = done_d ? id_q : done_id_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         bit_q <= '0;
         frame_q <= '0;
         ptr_q <= '0;
         id_q <= '0;
         ncs_q <= 1'b1;
         sclk_q <= 1'b0;
         copi_q <= 1'b0;
         done_q <= 1'b0;
         done_id_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         bit_q <= bit_d;
         frame_q <= frame_d;
         ptr_q <= ptr_d;
         id_q <= id_d;
         ncs_q <= ncs_d;
         sclk_q <= sclk_d;
         copi_q <= copi_d;
         done_q <= done_d;
         done_id_q <= done_id_d;
      end
   end

   // Gated by rst_n so no accept strobe escapes while reset is held.
   assign req_ready_o = (state_q == IDLE && rst_n) ? grant : '0;
   assign busy_o = state_q != IDLE;
   assign done_o = done_q;
   assign done_id_o = done_id_q;
   assign ncs_o = ncs_q;
   assign sclk_o = sclk_q;
   assign copi_o = copi_q;
endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// tb_spi_cfg_sequencer: vector table, hand-written corner sequences and random
// traffic checked against a pin-level SPI peripheral model and a round-robin model.
module tb_spi_cfg_sequencer;
   localparam int N = 2, D = 4, G = 8, D2 = 6, G2 = 4;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] valid = '0;
   logic [7*N-1:0] addr = '0;
   logic [8*N-1:0] data = '0;
   logic [N-1:0] ready;
   logic busy, done, ncs, sclk, copi;
   logic [2:0] done_id;
   logic v2 = 1'b0;
   logic [6:0] a2 = '0;
   logic [7:0] d2 = '0;
   logic r2, busy2, done2, ncs2, sclk2, copi2;
   logic [2:0] did2;

   spi_cfg_sequencer #(.NUM_REQ(N), .CLK_DIV(D), .CS_GAP(G)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid_i(valid), .req_addr_i(addr), .req_data_i(data),
      .req_ready_o(ready), .busy_o(busy), .done_o(done), .done_id_o(done_id),
      .ncs_o(ncs), .sclk_o(sclk), .copi_o(copi));

   spi_cfg_sequencer #(.NUM_REQ(1), .CLK_DIV(D2), .CS_GAP(G2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid_i(v2), .req_addr_i(a2), .req_data_i(d2),
      .req_ready_o(r2), .busy_o(busy2), .done_o(done2), .done_id_o(did2),
      .ncs_o(ncs2), .sclk_o(sclk2), .copi_o(copi2));

   logic use2 = 1'b0;
   logic m_ncs, m_sclk, m_copi, m_busy, m_done;
   logic [2:0] m_did;
   assign m_ncs = use2 ? ncs2 : ncs;
   assign m_sclk = use2 ? sclk2 : sclk;
   assign m_copi = use2 ? copi2 : copi;
   assign m_busy = use2 ? busy2 : busy;
   assign m_done = use2 ? done2 : done;
   assign m_did = use2 ? did2 : done_id;

   int tests = 0, fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {logic [15:0] f; int len;} obs_t;
   typedef struct {int id; int c;} dn_t;
   typedef struct {logic [15:0] f; int id; int g;} exp_t;
   obs_t oq[$];
   dn_t dq[$];
   logic [7:0] regs[128];
   logic ncs_p = 1'b1, sclk_p = 1'b0, copi_p = 1'b0;
   logic [15:0] sh = '0;
   int nb = 0, low_len = 0, gb = 0, last_gb = 0, ndone = 0, partial = 0, viol = 0;
   int rise_pos[16], fall_pos[16];

   // Pin-level peripheral: samples COPI on SCLK rise, commits only complete 16-bit frames.
   task automatic mon();
      if (ncs_p && !m_ncs) begin nb = 0; low_len = 0; end
      if (!m_ncs) low_len++;
      if (!m_ncs && m_sclk && !sclk_p) begin
         if (nb < 16) rise_pos[nb] = low_len;
         sh = {sh[14:0], m_copi};
         nb++;
      end
      if (!m_ncs && !m_sclk && sclk_p && nb >= 1 && nb <= 16) fall_pos[nb-1] = low_len;
      if ((m_sclk && m_copi != copi_p) || (m_ncs && (m_copi || m_sclk))) viol++;
      if (m_ncs && !ncs_p) begin
         if (nb == 16) begin
            oq.push_back('{sh, low_len});
            regs[sh[14:8]] = sh[7:0];
         end else partial++;
      end
      if (m_ncs && m_busy) gb++;
      else if (gb != 0) begin last_gb = gb; gb = 0; end
      if (m_done) begin ndone++; dq.push_back('{int'(m_did), cyc}); end
      ncs_p = m_ncs; sclk_p = m_sclk; copi_p = m_copi;
   endtask

   initial forever begin @(negedge clk); mon(); end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   int mptr = 0;

   task automatic drive(input int rid, input logic v, input logic [6:0] a, input logic [7:0] dv);
      if (use2) begin v2 = v; a2 = a; d2 = dv; end
      else begin valid[rid] = v; addr[7*rid +: 7] = a; data[8*rid +: 8] = dv; end
   endtask

   function automatic logic rdy(input int rid);
      return use2 ? r2 : ready[rid];
   endfunction

   task automatic wait_ready(input int rid, input int lim, output int g);
      g = -1;
      for (int k = 0; k < lim; k++) begin
         #1;
         if (rdy(rid)) begin g = cyc; break; end
         @(negedge clk);
      end
      if (g < 0) chk("ready_timeout", 0, 1);
   endtask

   task automatic single(input int rid, input logic [6:0] a, input logic [7:0] dv,
                         input logic [15:0] f, input int dd, input int gg);
      int g, n0, k, bad;
      obs_t ob;
      dn_t dn;
      oq.delete(); dq.delete(); n0 = ndone;
      @(negedge clk); drive(rid, 1'b1, a, dv);
      wait_ready(rid, 400, g);
      @(negedge clk); drive(rid, 1'b0, a, dv);
      if (g >= 0) mptr = (rid + 1) % N;
      k = 0;
      while (dq.size() == 0 && k < 40*dd + gg + 50) begin @(negedge clk); k++; end
      repeat (gg + 3) @(negedge clk);
      #1;
      if (oq.size() == 0) chk("frame_seen", 0, 1);
      else begin
         ob = oq.pop_front();
         chk("frame", ob.f, f);
         chk("ncs_low", ob.len, 33*dd);
      end
      if (dq.size() == 0) chk("done_seen", 0, 1);
      else begin
         dn = dq.pop_front();
         chk("done_id", dn.id, rid);
         chk("done_lat", dn.c - g, 33*dd + 1);
      end
      chk("done_pulses", ndone - n0, 1);
      bad = 0;
      for (int j = 0; j < 16; j++)
         if (rise_pos[j] != 1 + dd + 2*j*dd || fall_pos[j] != 2*dd + 1 + 2*j*dd) bad++;
      chk("sclk_edges", bad, 0);
      chk("reg_write", regs[a], dv);
      chk("gap_len", last_gb, gg);
   endtask

   typedef struct {int rid; logic [6:0] a; logic [7:0] d; logic [15:0] f;} vec_t;
   vec_t vt[5];

   initial begin
      int g, g0, g1, low, n, n0, p0, k, w;
      int gid[4], gc[4];
      logic [N-1:0] pend, gprev;
      logic [6:0] pa[N];
      logic [7:0] pd[N];
      exp_t eq[$];
      exp_t e;
      dn_t dn;
      obs_t ob;
      foreach (regs[i]) regs[i] = 8'h00;
      vt[0] = '{0, 7'h04, 8'hA5, 16'h84A5};
      vt[1] = '{1, 7'h7F, 8'h00, 16'hFF00};
      vt[2] = '{0, 7'h00, 8'hFF, 16'h80FF};
      vt[3] = '{1, 7'h2A, 8'h5C, 16'hAA5C};
      vt[4] = '{1, 7'h55, 8'h81, 16'hD581};

      repeat (3) @(negedge clk);
      #1;
      chk("reset_ncs", ncs, 1); chk("reset_sclk", sclk, 0); chk("reset_copi", copi, 0);
      chk("reset_ready", ready, 0); chk("reset_busy", busy, 0); chk("reset_done", done, 0);
      chk("reset_done_id", done_id, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) single(vt[i].rid, vt[i].a, vt[i].d, vt[i].f, D, G);

      // Requester 1 raises valid mid-frame and must wait for the first IDLE cycle.
      @(negedge clk); drive(0, 1'b1, 7'h10, 8'h11);
      wait_ready(0, 400, g0);
      @(negedge clk); drive(0, 1'b0, 7'h10, 8'h11);
      repeat (40) @(negedge clk);
      drive(1, 1'b1, 7'h11, 8'h22);
      low = 0; g1 = -1;
      for (int j = 0; j < 300; j++) begin
         #1;
         if (!busy) low++;
         if (ready[1]) begin g1 = cyc; break; end
         @(negedge clk);
      end
      chk("late_grant", g1 - g0, 33*D + G + 1);
      chk("busy_low_cycles", low, 1);
      @(negedge clk); drive(1, 1'b0, 7'h11, 8'h22);
      #1 chk("busy_after_grant", busy, 1);
      repeat (160) @(negedge clk);
      chk("mid_reg0", regs[7'h10], 8'h11);
      chk("mid_reg1", regs[7'h11], 8'h22);
      mptr = 0;

      // Both requesters hold valid: grants alternate at the back-to-back period.
      @(negedge clk); drive(0, 1'b1, 7'h00, 8'h40); drive(1, 1'b1, 7'h01, 8'h41);
      n = 0; k = 0;
      while (n < 4 && k < 800) begin
         #1;
         if (ready != 0) begin
            chk("b2b_onehot", $countones(ready), 1);
            gid[n] = ready[1] ? 1 : 0; gc[n] = cyc; n++;
         end
         @(negedge clk); k++;
      end
      drive(0, 1'b0, 7'h00, 8'h40); drive(1, 1'b0, 7'h01, 8'h41);
      chk("b2b_count", n, 4);
      for (int j = 0; j < n; j++) chk("b2b_id", gid[j], (mptr + j) % N);
      for (int j = 1; j < n; j++) chk("b2b_period", gc[j] - gc[j-1], 33*D + G + 1);
      if (n > 0) mptr = (gid[n-1] + 1) % N;
      repeat (160) @(negedge clk);
      chk("b2b_reg0", regs[0], 8'h40);
      chk("b2b_reg1", regs[1], 8'h41);

      // A valid withdrawn before its grant must never be served.
      n0 = ndone;
      @(negedge clk); drive(0, 1'b1, 7'h12, 8'h34);
      wait_ready(0, 400, g);
      @(negedge clk); drive(0, 1'b0, 7'h12, 8'h34);
      mptr = 1;
      repeat (20) @(negedge clk); drive(1, 1'b1, 7'h33, 8'h99);
      repeat (40) @(negedge clk); drive(1, 1'b0, 7'h33, 8'h99);
      n = 0;
      for (int j = 0; j < 250; j++) begin #1; if (ready[1]) n++; @(negedge clk); end
      chk("dropped_grants", n, 0);
      chk("dropped_reg", regs[7'h33], 0);
      chk("dropped_done_count", ndone - n0, 1);

      // Reset asserted at the 8th SCLK rising edge drops the frame.
      @(negedge clk); drive(0, 1'b1, 7'h05, 8'h77);
      wait_ready(0, 400, g);
      @(negedge clk); drive(0, 1'b0, 7'h05, 8'h77);
      k = 0;
      while (nb < 8 && k < 300) begin @(negedge clk); #1; k++; end
      chk("rise8_pos", rise_pos[7], 1 + D + 14*D);
      rst_n = 1'b0;
      #1;
      chk("rst_ncs", ncs, 1); chk("rst_sclk", sclk, 0); chk("rst_copi", copi, 0);
      chk("rst_busy", busy, 0); chk("rst_ready", ready, 0); chk("rst_done", done, 0);
      n0 = ndone; p0 = partial;
      repeat (3) @(negedge clk);
      rst_n = 1'b1; mptr = 0;
      repeat (200) @(negedge clk);
      chk("no_done_after_reset", ndone - n0, 0);
      chk("partial_dropped", partial - p0, 1);
      chk("aborted_reg", regs[5], 0);
      single(0, 7'h02, 8'h3C, 16'h823C, D, G);

      // Random traffic against a round-robin reference with ordered expectations.
      oq.delete(); dq.delete();
      pend = '0; gprev = '0;
      for (int i = 0; i < N; i++) begin pa[i] = '0; pd[i] = '0; end
      for (int c = 0; c < 4600; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (gprev[i]) pend[i] = 1'b0;
            if (c < 4000) begin
               if (!pend[i]) begin
                  if ($urandom_range(0, 9) == 0) begin
                     pend[i] = 1'b1; pa[i] = 7'($urandom); pd[i] = 8'($urandom);
                  end
               end else if ($urandom_range(0, 199) == 0) pend[i] = 1'b0;
            end
            valid[i] = pend[i]; addr[7*i +: 7] = pa[i]; data[8*i +: 8] = pd[i];
         end
         #1;
         gprev = ready;
         if (ready != 0) begin
            w = -1;
            for (int j = N - 1; j >= 0; j--) if (pend[(mptr + j) % N]) w = (mptr + j) % N;
            chk("rand_grant", ready, w < 0 ? 0 : (1 << w));
            if (w >= 0) begin
               eq.push_back('{{1'b1, pa[w], pd[w]}, w, cyc});
               mptr = (w + 1) % N;
            end
         end
         while (dq.size() > 0) begin
            dn = dq.pop_front();
            if (eq.size() == 0) chk("rand_spurious_done", 1, 0);
            else begin
               e = eq.pop_front();
               chk("rand_done_id", dn.id, e.id);
               chk("rand_done_lat", dn.c - e.g, 33*D + 1);
               if (oq.size() == 0) chk("rand_frame_seen", 0, 1);
               else begin ob = oq.pop_front(); chk("rand_frame", ob.f, e.f); end
            end
         end
      end
      chk("rand_outstanding", eq.size(), 0);

      // Second configuration: CLK_DIV=6, CS_GAP=4, one requester.
      valid = '0;
      repeat (5) @(negedge clk);
      use2 = 1'b1;
      repeat (3) @(negedge clk);
      single(0, 7'h09, 8'h6E, 16'h896E, D2, G2);
      oq.delete(); dq.delete();
      @(negedge clk); drive(0, 1'b1, 7'h0A, 8'h01);
      n = 0; k = 0;
      while (n < 2 && k < 600) begin
         #1;
         if (r2) begin gc[n] = cyc; n++; end
         @(negedge clk); k++;
      end
      drive(0, 1'b0, 7'h0A, 8'h01);
      chk("d2_grants", n, 2);
      if (n == 2) chk("d2_period", gc[1] - gc[0], 33*D2 + G2 + 1);
      repeat (250) @(negedge clk);
      chk("d2_frames", oq.size(), 2);
      while (oq.size() > 0) begin ob = oq.pop_front(); chk("d2_ncs_low", ob.len, 33*D2); end
      chk("d2_reg", regs[7'h0A], 8'h01);
      chk("protocol_viol", viol, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
